// File: rtl/motor_pkg.sv
// motor_pkg: shared move codes, level type, FSM states and ramp step helper for motor_pwm_driver
package motor_pkg;
  localparam logic [3:0] CMD_W = 4'b0000;
  localparam logic [3:0] CMD_WA = 4'b0001;
  localparam logic [3:0] CMD_WD = 4'b0010;
  localparam int LEVEL_MAX = 15;
  typedef logic [3:0] level_t;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  function automatic level_t step_toward(level_t cur, level_t tgt);
    return cur < tgt ? cur + 4'd1 : cur > tgt ? cur - 4'd1 : cur;
  endfunction
endpackage

// File: rtl/motor_pwm_driver_wheel_ramp.sv
// wheel_ramp: one wheel's rate-limited level register plus registered PWM compare
// ports: clk, reset (async, active-high), target, period_tick, ramp_tick, cnt (shared period counter) -> pwm, level
// MOTOR_DEADBAND_EN: non-zero levels below MIN_LEVEL are raised to MIN_LEVEL on pwm and level
module wheel_ramp
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD = 2500,
  parameter int MIN_LEVEL = 3,
  localparam int CW = $clog2(PWM_PERIOD)
) (
  input  logic          clk,
  input  logic          reset,
  input  level_t        target,
  input  logic          period_tick,
  input  logic          ramp_tick,
  input  logic [CW-1:0] cnt,
  output logic          pwm,
  output level_t        level
);
  localparam logic [CW-1:0] STEP = CW'(PWM_PERIOD / 15);
`ifdef MOTOR_DEADBAND_EN
  localparam bit DEADBAND = 1'b1;
`else
  localparam bit DEADBAND = 1'b0;
`endif
  level_t raw;
  logic [CW-1:0] thr;
  // the ramp itself walks through the stall zone one step per tick; only the driven value is floored
  assign level = (DEADBAND && raw != '0 && raw < level_t'(MIN_LEVEL)) ? level_t'(MIN_LEVEL) : raw;
  assign thr = CW'(level) * STEP;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      raw <= '0;
      pwm <= 1'b0;
    end else begin
      if (period_tick && ramp_tick) raw <= step_toward(raw, target);
      pwm <= level == level_t'(LEVEL_MAX) ? 1'b1 : level == '0 ? 1'b0 : cnt < thr;
    end
endmodule

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: maps move_cmd/speed_level to ramped differential-drive wheel PWM
// ports: clk, reset (async, active-high), enable, move_cmd, speed_level -> pwm_left/right, level_left/right, running
// MOTOR_DEADBAND_EN: floors non-zero wheel levels at MIN_LEVEL
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD = 2500,
  parameter int BASE_LEVEL = 8,
  parameter int RAMP_PERIODS = 4,
  parameter int MIN_LEVEL = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] move_cmd,
  input  logic [3:0] speed_level,
  output logic       pwm_left,
  output logic       pwm_right,
  output level_t     level_left,
  output level_t     level_right,
  output logic       running
);
  localparam int CW = $clog2(PWM_PERIOD);
  localparam int RW = $clog2(RAMP_PERIODS + 1);
  localparam logic [CW-1:0] LAST = CW'(PWM_PERIOD - 1);
  localparam logic [RW-1:0] RLAST = RW'(RAMP_PERIODS - 1);
  localparam level_t BASE = level_t'(BASE_LEVEL);
  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic period_tick, ramp_tick;
  logic [4:0] sum;
  level_t lo, hi, t_left, t_right;
  state_t state;
  assign period_tick = cnt == LAST;
  assign ramp_tick = state != IDLE && rcnt == RLAST;
  assign sum = {1'b0, BASE} + {1'b0, speed_level};
  assign hi = sum[4] ? level_t'(LEVEL_MAX) : sum[3:0];
  assign lo = speed_level >= BASE ? '0 : BASE - speed_level;
  // targets are only consumed on period_tick, so mid-period changes wait for the boundary
  assign t_left = !enable ? '0 : move_cmd == CMD_W ? BASE : move_cmd == CMD_WA ? lo : move_cmd == CMD_WD ? hi : '0;
  assign t_right = !enable ? '0 : move_cmd == CMD_W ? BASE : move_cmd == CMD_WA ? hi : move_cmd == CMD_WD ? lo : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      rcnt <= '0;
    end else begin
      cnt <= period_tick ? '0 : cnt + 1'b1;
      rcnt <= state == IDLE ? '0 : !period_tick ? rcnt : rcnt == RLAST ? '0 : rcnt + 1'b1;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      running <= 1'b0;
    end else if (period_tick)
      case (state)
        IDLE: if (enable) begin
          state <= RUN;
          running <= 1'b1;
        end
        RUN: if (!enable) state <= STOPPING;
        STOPPING:
          if (enable) state <= RUN;
          else if (level_left == '0 && level_right == '0) begin
            state <= IDLE;
            running <= 1'b0;
          end
        default: begin
          state <= IDLE;
          running <= 1'b0;
        end
      endcase
  wheel_ramp #(.PWM_PERIOD(PWM_PERIOD), .MIN_LEVEL(MIN_LEVEL)) u_left (
    .clk(clk), .reset(reset), .target(t_left), .period_tick(period_tick),
    .ramp_tick(ramp_tick), .cnt(cnt), .pwm(pwm_left), .level(level_left)
  );
  wheel_ramp #(.PWM_PERIOD(PWM_PERIOD), .MIN_LEVEL(MIN_LEVEL)) u_right (
    .clk(clk), .reset(reset), .target(t_right), .period_tick(period_tick),
    .ramp_tick(ramp_tick), .cnt(cnt), .pwm(pwm_right), .level(level_right)
  );
endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
Downstream of the steering controller. Consumes its move_cmd/speed_level pair and drives two wheel PWM outputs for a differential-drive chassis. Per-wheel targets are rate-limited by a ramp stage so abrupt steering changes do not jerk the motors. A small FSM handles start-up and controlled stopping.

Parameters:
PWM_PERIOD, 2500, clocks per PWM period (20 kHz at 50 MHz); must be >= 15
BASE_LEVEL, 8, straight-ahead wheel level (0..15)
RAMP_PERIODS, 4, PWM periods per one-level ramp step (>= 1)
MIN_LEVEL, 3, lowest non-zero level when MOTOR_DEADBAND_EN is defined

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
enable  in  1  1 = drive; 0 = ramp both wheels to stop
move_cmd  in  4  0000 = straight, 0001 = left turn, 0010 = right turn, others = stop
speed_level  in  4  steering magnitude 0..15
pwm_left  out  1  left wheel PWM
pwm_right  out  1  right wheel PWM
level_left  out  4  current ramped left level
level_right  out  4  current ramped right level
running  out  1  FSM not in IDLE

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock. On reset: pwm_* = 0, level_* = 0, running = 0, period counter = 0, ramp counter = 0, FSM = IDLE.
- Period counter runs 0..PWM_PERIOD-1 and wraps. period_tick is asserted when the counter equals PWM_PERIOD-1.
- Target mapping is combinational, saturating in 5-bit then clamped to 0..15:
  - straight: L = R = BASE_LEVEL.
  - left turn: L = max(BASE-speed, 0), R = min(BASE+speed, 15).
  - right turn: mirror of left turn.
  - any other code, or enable = 0: L = R = 0.
- Targets are sampled only on period_tick, so a mid-period command change has no effect until the next boundary.
- Ramp counter counts period_ticks 0..RAMP_PERIODS-1. On its wrap, each level moves one step toward its target (+1, -1, or hold).
  - Levels update only on a period_tick and are stable for the whole following period.
- PWM output: STEP = PWM_PERIOD/15 (integer division).
  - pwm = 1 when counter < level*STEP.
  - level 15 forces pwm = 1 for the whole period.
  - level 0 forces pwm = 0 for the whole period.
  - pwm is registered, one cycle behind the counter compare.
- FSM:
  - IDLE -> RUN on the first period_tick with enable = 1.
  - RUN -> STOPPING on a period_tick with enable = 0.
  - STOPPING -> RUN if enable returns to 1 (checked at period_tick).
  - STOPPING -> IDLE at the period_tick where both levels are 0.
  - In IDLE, levels are held at 0 and the ramp counter is held at 0.
- A reset mid-period clears everything immediately; the outputs must not glitch high afterwards.

Optional Feature:
MOTOR_DEADBAND_EN
- Defined: any non-zero ramped level below MIN_LEVEL is output as MIN_LEVEL, because the motors stall below that level. This applies to both the PWM compare and the level_* outputs. Ramping through the 1..MIN_LEVEL-1 zone still takes one step per ramp tick.
- Undefined: levels are used unmodified.

Decomposition:
- Package motor_pkg:
  - move code localparams CMD_W = 4'b0000, CMD_WA = 4'b0001, CMD_WD = 4'b0010.
  - typedef level_t (logic [3:0]).
  - FSM enum {IDLE, RUN, STOPPING}.
  - LEVEL_MAX = 15.
- Sub-module wheel_ramp, instantiated twice. It takes target, period_tick, ramp_tick and the shared counter, and holds the level register plus the PWM compare. The top level holds the period counter, ramp counter, target mapping and FSM.

Test Plan:
Bench parameters: PWM_PERIOD = 150 (STEP = 10), RAMP_PERIODS = 1, BASE_LEVEL = 8, macro undefined unless stated.
1. enable = 1, move_cmd = 0000 from reset -> running = 1 after first tick; levels step 0->8 over 8 periods; then pwm_* high for 80 of every 150 cycles.
2. From steady 8/8, apply move_cmd = 0001, speed = 3 -> after 3 ramp steps L = 5, R = 11; pwm_left high 50 cycles, pwm_right high 110 cycles.
3. move_cmd = 0010, speed = 12 -> L ramps to 15, pwm_left high all 150 cycles; R ramps to 0, pwm_right constant 0.
4. move_cmd = 0011 while enable = 1 -> both targets 0; levels decrement 1 per period; running stays 1.
5. Drop enable at 8/8 -> STOPPING; 8 periods later both levels are 0 and running = 0. Re-raise enable at level 4 -> returns to RUN and ramps up from 4.
6. Assert reset mid-period at levels 8/8 -> pwm_*, level_* and running are 0 within the same cycle with no further pwm pulses. With MOTOR_DEADBAND_EN and target 1 -> level_left reads 3, pwm high 30 cycles.
